// File: rtl/axis_to_rs232.sv
// rtl/axis_to_rs232.sv - stream-to-RS232 8N1/8N2 transmitter with CTS flow control
module axis_to_rs232 #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd_pin,
    input  logic       ctsn_pin,
    output logic       busy
);

    // Real-to-int cast rounds to nearest, giving clocks per bit.
    localparam int BAUD_COUNT = int'(CLOCK_FREQ / BAUD_RATE);
    localparam int TW         = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(BAUD_COUNT - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (BAUD_COUNT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
            $error("axis_to_rs232: BAUD_COUNT must be >= 2 and STOP_BITS 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [8:0]      shift;
    logic [TW-1:0]   timer;
    logic [3:0]      bit_cnt;
    logic [1:0]      cts_sync;
    logic            cts_n;
    logic            handshake;
    logic            tick;

    assign cts_n     = cts_sync[1];
    // Only registered state feeds iready, so ivalid never loops back into it.
    assign iready    = (state == IDLE) && !cts_n;
    assign handshake = ivalid && iready;
    assign tick      = (state != IDLE) && (timer == '0);

    // Two-flop synchroniser for the receiver's RTSn; resets to "not ready".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], ctsn_pin};
        end
    end

    // Frame sequencer; txd and busy are registered views of the current phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= 9'h1ff;
            timer   <= RELOAD;
            bit_cnt <= 4'd0;
            txd_pin <= 1'b1;
            busy    <= 1'b0;
        end else begin
            txd_pin <= (state != IDLE) ? shift[0] : 1'b1;
            busy    <= (state != IDLE);

            // Timer free-runs only inside a frame; each tick reloads it so bits never drift.
            if (state != IDLE) begin
                if (timer == '0) begin
                    timer <= RELOAD;
                end else begin
                    timer <= timer - 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        shift   <= {idata, 1'b0};
                        timer   <= RELOAD;
                        bit_cnt <= 4'd0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        shift   <= {1'b1, shift[8:1]};
                        bit_cnt <= 4'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= {1'b1, shift[8:1]};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    // Shift register is all ones here, so txd stays high.
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= 4'd0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
